// File: rtl/serial_pkg.sv
// Shared types and constants for the serial sequence detector path.
package serial_pkg;

  // Serializer state: IDLE has an empty shift register, SHIFT drives one live bit per cycle.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit-order selectors, shared with the detector-side bench.
  localparam bit ORDER_MSB = 1'b1;
  localparam bit ORDER_LSB = 1'b0;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word input handshake and serial-bit output bundle of the bit serializer.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 11
);

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             x;
  logic             x_valid;
  logic             word_done;
  logic             busy;

  // Word producer / serial consumer side.
  modport master (
    output word_in,
    output word_valid,
    input  word_ready,
    input  x,
    input  x_valid,
    input  word_done,
    input  busy
  );

  // Serializer side.
  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready,
    output x,
    output x_valid,
    output word_done,
    output busy
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one word in the shift register plus a one-word holding
// register, so a queued word starts on the cycle after the previous word's last bit.
// WIDTH must be at least 2.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 11,
  parameter bit          MSB_FIRST = ORDER_MSB
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int unsigned          CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]      CntLast = CntW'(WIDTH - 1);
  localparam bit                   MsbOut  = (MSB_FIRST == ORDER_MSB);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             in_shift;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] sr_shift;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == CntLast);
  // Ready depends only on the holding register, so a full hold blocks new words even on the
  // last-bit edge; an empty hold lets a word land straight in sr on that edge.
  assign ready    = ~hold_full_q & ~reset;
  assign accept   = bus.word_valid & ready;

  // Outgoing bit always sits at the exit end; the register moves toward it each cycle.
  assign sr_shift = MsbOut ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  // Next-state logic: load, shift, refill from hold or from the input, or fall idle.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = bus.word_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          cnt_d = cnt_q + CntW'(1);
          sr_d  = sr_shift;
          if (accept) begin
            hold_d      = bus.word_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Queued word takes over with no bubble; ready is low so no accept can collide.
          sr_d        = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
        end else if (accept) begin
          sr_d  = bus.word_in;
          cnt_d = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards both the active and held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bus.word_ready = ready;
  assign bus.x_valid    = in_shift;
  assign bus.x          = in_shift & (MsbOut ? sr_q[WIDTH-1] : sr_q[0]);
  assign bus.word_done  = last_bit;
  assign bus.busy       = in_shift | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one stimulus and
// are checked every cycle against a word-queue model, plus literal bit-sequence checks.
module tb_bit_serializer;
  import serial_pkg::*;

  localparam int unsigned W = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) bus_m ();
  bit_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.word_in    = word_in;
  assign bus_m.word_valid = word_valid;
  assign bus_l.word_in    = word_in;
  assign bus_l.word_valid = word_valid;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(ORDER_MSB)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(ORDER_LSB)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of accepted words; head word is on the wire, pos is its current bit index.
  logic [W-1:0] mq[$];
  int  pos = 0;
  int  cyc = 0;
  bit  started = 1'b0;

  initial begin
    bit           acc;
    logic [W-1:0] w;
    forever begin
      @(posedge clk);
      acc = word_valid && !reset && (mq.size() < 2);
      w   = word_in;
      if (reset) begin
        mq.delete();
        pos = 0;
      end else begin
        if (mq.size() > 0) begin
          pos++;
          if (pos == W) begin
            void'(mq.pop_front());
            pos = 0;
          end
        end
        if (acc) mq.push_back(w);
      end
      cyc++;
      started = 1'b1;
    end
  end

  // Capture of the serial stream for literal checks.
  logic cap_m [512];
  logic cap_l [512];
  int   cap_n = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   done_cyc [32];
  int   done_n = 0;

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    logic [W-1:0] hw;
    logic ev, exm, exl, ed, eb, er;
    forever begin
      @(negedge clk);
      if (started) begin
        ev = 1'b0; exm = 1'b0; exl = 1'b0; ed = 1'b0;
        if (mq.size() > 0) begin
          hw  = mq[0];
          ev  = 1'b1;
          exm = hw[W-1-pos];
          exl = hw[pos];
          ed  = (pos == W - 1);
        end
        eb = (mq.size() > 0);
        er = !reset && (mq.size() < 2);
        check("msb_x",       bus_m.x,          exm);
        check("msb_x_valid", bus_m.x_valid,    ev);
        check("msb_done",    bus_m.word_done,  ed);
        check("msb_busy",    bus_m.busy,       eb);
        check("msb_ready",   bus_m.word_ready, er);
        check("lsb_x",       bus_l.x,          exl);
        check("lsb_x_valid", bus_l.x_valid,    ev);
        check("lsb_done",    bus_l.word_done,  ed);
        check("lsb_busy",    bus_l.busy,       eb);
        check("lsb_ready",   bus_l.word_ready, er);
        if (bus_m.x_valid === 1'b1 && cap_n < 512) begin
          cap_m[cap_n] = bus_m.x;
          cap_l[cap_n] = bus_l.x;
          if (cap_n == 0) first_cyc = cyc;
          last_cyc = cyc;
          cap_n++;
        end
        if (bus_m.word_done === 1'b1 && done_n < 32) begin
          done_cyc[done_n] = cyc;
          done_n++;
        end
      end
    end
  end

  task automatic clear_cap();
    cap_n  = 0;
    done_n = 0;
  endtask

  function automatic logic [W-1:0] packed_m(input int start);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = cap_m[start+i];
    return r;
  endfunction

  function automatic logic [W-1:0] packed_l(input int start);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = cap_l[start+i];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic send(input logic [W-1:0] w);
    bit ok;
    bit r;
    ok = 1'b0;
    word_in    = w;
    word_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      r = bus_m.word_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    word_valid = 1'b0;
    word_in    = W'($urandom);
    check("send_accept", ok, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_a, acc_b, acc_c, v;

    // Reset, then post-reset outputs.
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready",   bus_m.word_ready, 1);
    check("rst_x_valid", bus_m.x_valid,    0);
    check("rst_busy",    bus_m.busy,       0);
    check("rst_x",       bus_m.x,          0);

    // Idle: no valid input for 20 cycles.
    clear_cap();
    idle(20);
    check("idle_bits", cap_n,  0);
    check("idle_done", done_n, 0);

    // Single word 11'b01011101100.
    clear_cap();
    send(11'b01011101100);
    acc_a = cyc;
    idle(14);
    check("single_len",     cap_n,       11);
    check("single_msb_seq", packed_m(0), 11'b01011101100);
    check("single_lsb_seq", packed_l(0), 11'h1BA);
    check("single_latency", first_cyc,   acc_a);
    check("single_done_n",  done_n,      1);
    check("single_done_at", done_cyc[0], last_cyc);

    // Back-to-back A, B, then C under back-pressure.
    clear_cap();
    send(11'h2EC);
    acc_a = cyc;
    send(11'h5A5);
    send(11'h3C3);
    acc_c = cyc;
    idle(40);
    check("b2b_len",        cap_n,                   33);
    check("b2b_word_a",     packed_m(0),             11'h2EC);
    check("b2b_word_b",     packed_m(11),            11'h5A5);
    check("b2b_word_c",     packed_m(22),            11'h3C3);
    check("b2b_contiguous", last_cyc - first_cyc + 1, 33);
    check("b2b_done_n",     done_n,                  3);
    check("b2b_done_gap1",  done_cyc[1] - done_cyc[0], 11);
    check("b2b_done_gap2",  done_cyc[2] - done_cyc[1], 11);
    check("backpressure_wait", acc_c - acc_a,        12);

    // Accept on the last-bit edge with hold empty.
    clear_cap();
    send(11'h0F0);
    acc_a = cyc;
    idle(10);
    send(11'h70F);
    acc_b = cyc;
    idle(15);
    check("edge_accept_cycle", acc_b - acc_a,            11);
    check("edge_len",          cap_n,                    22);
    check("edge_contiguous",   last_cyc - first_cyc + 1, 22);
    check("edge_word_a",       packed_m(0),              11'h0F0);
    check("edge_word_b",       packed_m(11),             11'h70F);

    // Reset at A's bit 5 while B is held.
    clear_cap();
    send(11'h2EC);
    send(11'h5A5);
    idle(4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_x_valid", bus_m.x_valid,    0);
    check("mid_rst_busy",    bus_m.busy,       0);
    check("mid_rst_ready",   bus_m.word_ready, 1);
    idle(5);
    v = 0;
    for (int i = 0; i < 6 && i < cap_n; i++) v = v * 2 + int'(cap_m[i]);
    check("mid_rst_partial_len",  cap_n,  6);
    check("mid_rst_partial_bits", v,      32'h17);
    check("mid_rst_no_done",      done_n, 0);
    clear_cap();
    send(11'h155);
    idle(14);
    check("post_rst_len",  cap_n,       11);
    check("post_rst_word", packed_m(0), 11'h155);
    check("post_rst_done", done_n,      1);

    // Bit order on 11'h001.
    clear_cap();
    send(11'h001);
    idle(14);
    check("order_len", cap_n,       11);
    check("order_lsb", packed_l(0), 11'h400);
    check("order_msb", packed_m(0), 11'h001);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
